// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the unified-memory arbiter.
// The response-owner encoding is used by both the RTL and the bench.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        OWN_NONE  = 2'd0,
        OWN_FETCH = 2'd1,
        OWN_DATA  = 2'd2
    } owner_t;

    localparam int DEF_ADDR_W          = 32;
    localparam int DEF_DATA_W          = 32;
    localparam int DEF_MAX_DATA_STREAK = 4;

endpackage

// File: rtl/mem_arbiter_if.sv
// Core-side and memory-side bus of the arbiter.
// The slave modport is the arbiter's view; master is the core plus the memory macro.
interface mem_arbiter_if
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);
    // fetch stage
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              flush;
    logic              if_gnt;
    logic              if_rvalid;
    logic [DATA_W-1:0] if_rdata;
    logic              stall_f;
    // memory stage
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_gnt;
    logic              d_rvalid;
    logic [DATA_W-1:0] d_rdata;
    logic              stall_m;
    // memory macro
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  if_req, if_addr, flush, d_req, d_we, d_addr, d_wdata, mem_rdata,
        output if_gnt, if_rvalid, if_rdata, stall_f,
        output d_gnt, d_rvalid, d_rdata, stall_m,
        output mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output if_req, if_addr, flush, d_req, d_we, d_addr, d_wdata, mem_rdata,
        input  if_gnt, if_rvalid, if_rdata, stall_f,
        input  d_gnt, d_rvalid, d_rdata, stall_m,
        input  mem_en, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/arb_streak_ctr.sv
// Saturating count of consecutive data grants taken while fetch was waiting.
// at_max tells the arbiter that fetch must win the next contended cycle.
module arb_streak_ctr #(
    parameter int MAX = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic at_max
);
    localparam int CW = $clog2(MAX + 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != CW'(MAX))) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign at_max = (cnt_q == CW'(MAX));

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates one single-ported synchronous memory between fetch and data accesses.
// Data has priority, bounded by a streak limit so fetch always makes progress.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W          = DEF_ADDR_W,
    parameter int DATA_W          = DEF_DATA_W,
    parameter int MAX_DATA_STREAK = DEF_MAX_DATA_STREAK
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  bus
);
    logic   at_max;
    logic   data_win;
    logic   fetch_win;
    owner_t owner_q;
    owner_t owner_d;
    logic   kill_q;
    logic   kill_d;
    logic   if_rvalid_w;
    logic   d_rvalid_w;

    // Grants are gated by reset so nothing reaches the memory while rst is low.
    assign data_win  = rst & bus.d_req & (~bus.if_req | ~at_max);
    assign fetch_win = rst & bus.if_req & ~data_win;

    assign bus.d_gnt   = data_win;
    assign bus.if_gnt  = fetch_win;
    assign bus.stall_f = rst & bus.if_req & ~fetch_win;
    assign bus.stall_m = rst & bus.d_req & ~data_win;

    assign bus.mem_en    = data_win | fetch_win;
    assign bus.mem_we    = data_win & bus.d_we;
    assign bus.mem_addr  = data_win  ? bus.d_addr :
                           fetch_win ? bus.if_addr : '0;
    assign bus.mem_wdata = data_win  ? bus.d_wdata : '0;

    arb_streak_ctr #(
        .MAX (MAX_DATA_STREAK)
    ) u_streak (
        .clk    (clk),
        .rst    (rst),
        .inc    (data_win & bus.if_req),
        .clr    (fetch_win | ~bus.if_req),
        .at_max (at_max)
    );

    always_comb begin
        owner_d = OWN_NONE;
        if (data_win && !bus.d_we) begin
            owner_d = OWN_DATA;
        end else if (fetch_win) begin
            owner_d = OWN_FETCH;
        end
    end

    // A redirect in the grant cycle kills the fetch word that arrives next cycle.
    assign kill_d = fetch_win & bus.flush;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner_q <= OWN_NONE;
            kill_q  <= 1'b0;
        end else begin
            owner_q <= owner_d;
            kill_q  <= kill_d;
        end
    end

    assign if_rvalid_w = (owner_q == OWN_FETCH) & ~kill_q & ~bus.flush;
    assign d_rvalid_w  = (owner_q == OWN_DATA);

    assign bus.if_rvalid = if_rvalid_w;
    assign bus.d_rvalid  = d_rvalid_w;
    assign bus.if_rdata  = if_rvalid_w ? bus.mem_rdata : '0;
    assign bus.d_rdata   = d_rvalid_w  ? bus.mem_rdata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed vector table, reset-mid-read sequence and random traffic
// checked against a transaction-level reference model of the arbitration rules.
module tb_mem_arbiter;
    localparam int MAXS = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_arbiter #(
        .ADDR_W          (32),
        .DATA_W          (32),
        .MAX_DATA_STREAK (MAXS)
    ) dut (
        .clk (clk),
        .rst (rst_n),
        .bus (bus)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000 ^ a;
    endfunction

    // Memory macro: synchronous single port, read data valid the cycle after.
    logic [31:0] macro_mem [logic [31:0]];
    initial bus.mem_rdata = '0;
    always @(posedge clk) begin
        if (bus.mem_en) begin
            if (bus.mem_we) macro_mem[bus.mem_addr] = bus.mem_wdata;
            else bus.mem_rdata <= macro_mem.exists(bus.mem_addr) ? macro_mem[bus.mem_addr]
                                                                 : init_word(bus.mem_addr);
        end
    end

    // Reference model: streak of data wins, one pending response, its value and kill flag.
    int          m_streak;
    int          m_pend;       // 0 none, 1 fetch word, 2 load word
    logic        m_kill;
    logic [31:0] m_pdata;
    logic [31:0] ref_mem [logic [31:0]];

    function automatic logic [31:0] ref_read(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
    endfunction

    task automatic model_reset();
        m_streak = 0;
        m_pend   = 0;
        m_kill   = 1'b0;
        m_pdata  = '0;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    // Drives one cycle's inputs (caller is at a negedge), checks every output, advances model.
    task automatic apply(input logic ir, input logic [31:0] ia, input logic fl,
                         input logic dr, input logic dwe, input logic [31:0] da,
                         input logic [31:0] dwd,
                         output logic a_ig, output logic a_dg, output logic a_irv,
                         output logic a_drv, output logic [31:0] a_drd);
        logic e_dg, e_ig, e_irv, e_drv;
        logic [31:0] e_addr;
        bus.if_req = ir; bus.if_addr = ia; bus.flush = fl;
        bus.d_req = dr; bus.d_we = dwe; bus.d_addr = da; bus.d_wdata = dwd;
        #1;
        e_dg   = dr && (!ir || m_streak < MAXS);
        e_ig   = ir && !e_dg;
        e_irv  = (m_pend == 1) && !m_kill && !fl;
        e_drv  = (m_pend == 2);
        e_addr = e_dg ? da : (e_ig ? ia : 32'h0);
        chk("d_gnt",     32'(bus.d_gnt),     32'(e_dg));
        chk("if_gnt",    32'(bus.if_gnt),    32'(e_ig));
        chk("stall_f",   32'(bus.stall_f),   32'(ir && !e_ig));
        chk("stall_m",   32'(bus.stall_m),   32'(dr && !e_dg));
        chk("mem_en",    32'(bus.mem_en),    32'(e_dg || e_ig));
        chk("mem_we",    32'(bus.mem_we),    32'(e_dg && dwe));
        chk("mem_addr",  bus.mem_addr,       e_addr);
        chk("mem_wdata", bus.mem_wdata,      e_dg ? dwd : 32'h0);
        chk("if_rvalid", 32'(bus.if_rvalid), 32'(e_irv));
        chk("if_rdata",  bus.if_rdata,       e_irv ? m_pdata : 32'h0);
        chk("d_rvalid",  32'(bus.d_rvalid),  32'(e_drv));
        chk("d_rdata",   bus.d_rdata,        e_drv ? m_pdata : 32'h0);
        $display("cyc %0d ir=%0b ia=%h dr=%0b we=%0b da=%h fl=%0b | ig=%0b dg=%0b irv=%0b drv=%0b",
                 cyc, ir, ia, dr, dwe, da, fl, bus.if_gnt, bus.d_gnt, bus.if_rvalid, bus.d_rvalid);
        a_ig = bus.if_gnt; a_dg = bus.d_gnt; a_irv = bus.if_rvalid;
        a_drv = bus.d_rvalid; a_drd = bus.d_rdata;
        // advance to the state after the coming rising edge
        m_kill = e_ig && fl;
        if (e_dg && !dwe)  begin m_pend = 2; m_pdata = ref_read(da); end
        else if (e_ig)     begin m_pend = 1; m_pdata = ref_read(ia); end
        else               begin m_pend = 0; m_pdata = '0; end
        if (e_dg && dwe) ref_mem[da] = dwd;
        if (e_ig || !ir)   m_streak = 0;
        else if (e_dg)     m_streak = (m_streak < MAXS) ? m_streak + 1 : MAXS;
        cyc++;
    endtask

    task automatic step(input logic ir, input logic [31:0] ia, input logic fl,
                        input logic dr, input logic dwe, input logic [31:0] da,
                        input logic [31:0] dwd);
        logic g0, g1, v0, v1;
        logic [31:0] rd;
        @(negedge clk);
        apply(ir, ia, fl, dr, dwe, da, dwd, g0, g1, v0, v1, rd);
    endtask

    typedef struct {
        logic        ir;
        logic [31:0] ia;
        logic        fl;
        logic        dr;
        logic        dwe;
        logic [31:0] da;
        logic [31:0] dwd;
        logic        e_ig;
        logic        e_dg;
        logic        e_irv;
        logic        e_drv;
        logic        chk_rd;
        logic [31:0] e_drd;
    } vec_t;

    function automatic vec_t mk(input logic ir, input logic [31:0] ia, input logic fl,
                                input logic dr, input logic dwe, input logic [31:0] da,
                                input logic [31:0] dwd, input logic ig, input logic dg,
                                input logic irv, input logic drv,
                                input logic crd, input logic [31:0] drd);
        vec_t v;
        v = '{ir, ia, fl, dr, dwe, da, dwd, ig, dg, irv, drv, crd, drd};
        return v;
    endfunction

    vec_t tbl [22];

    initial begin
        logic g_if, g_d, rv_if, rv_d;
        logic [31:0] rd;
        // fetch streaming
        tbl[0]  = mk(1, 32'h00, 0, 0, 0, 0,       0,            1, 0, 0, 0, 0, 0);
        tbl[1]  = mk(1, 32'h04, 0, 0, 0, 0,       0,            1, 0, 1, 0, 0, 0);
        tbl[2]  = mk(1, 32'h08, 0, 0, 0, 0,       0,            1, 0, 1, 0, 0, 0);
        // contention: load wins, fetch stalls
        tbl[3]  = mk(1, 32'h0C, 0, 1, 0, 32'h100, 0,            0, 1, 1, 0, 0, 0);
        tbl[4]  = mk(0, 0,      0, 0, 0, 0,       0,            0, 0, 0, 1, 0, 0);
        // starvation guard: four data wins then one fetch
        tbl[5]  = mk(1, 32'h10, 0, 1, 0, 32'h104, 0,            0, 1, 0, 0, 0, 0);
        tbl[6]  = mk(1, 32'h10, 0, 1, 0, 32'h108, 0,            0, 1, 0, 1, 0, 0);
        tbl[7]  = mk(1, 32'h10, 0, 1, 0, 32'h10C, 0,            0, 1, 0, 1, 0, 0);
        tbl[8]  = mk(1, 32'h10, 0, 1, 0, 32'h110, 0,            0, 1, 0, 1, 0, 0);
        tbl[9]  = mk(1, 32'h10, 0, 1, 0, 32'h114, 0,            1, 0, 0, 1, 0, 0);
        tbl[10] = mk(1, 32'h14, 0, 1, 0, 32'h118, 0,            0, 1, 1, 0, 0, 0);
        // store then read back
        tbl[11] = mk(0, 0,      0, 1, 1, 32'h200, 32'hDEADBEEF, 0, 1, 0, 1, 0, 0);
        tbl[12] = mk(0, 0,      0, 0, 0, 0,       0,            0, 0, 0, 0, 0, 0);
        tbl[13] = mk(0, 0,      0, 1, 0, 32'h200, 0,            0, 1, 0, 0, 0, 0);
        tbl[14] = mk(0, 0,      0, 0, 0, 0,       0,            0, 0, 0, 1, 1, 32'hDEADBEEF);
        // flush in grant cycle, then flush in response cycle
        tbl[15] = mk(1, 32'h20, 1, 0, 0, 0,       0,            1, 0, 0, 0, 0, 0);
        tbl[16] = mk(1, 32'h24, 0, 0, 0, 0,       0,            1, 0, 0, 0, 0, 0);
        tbl[17] = mk(1, 32'h28, 1, 0, 0, 0,       0,            1, 0, 0, 0, 0, 0);
        tbl[18] = mk(0, 0,      0, 0, 0, 0,       0,            0, 0, 0, 0, 0, 0);
        tbl[19] = mk(0, 0,      0, 0, 0, 0,       0,            0, 0, 0, 0, 0, 0);
        // flush leaves loads alone
        tbl[20] = mk(0, 0,      1, 1, 0, 32'h104, 0,            0, 1, 0, 0, 0, 0);
        tbl[21] = mk(0, 0,      1, 0, 0, 0,       0,            0, 0, 0, 1, 0, 0);

        // reset: requests present but everything held at zero
        bus.if_req = 1; bus.if_addr = 32'h40; bus.flush = 0;
        bus.d_req = 1; bus.d_we = 1; bus.d_addr = 32'h44; bus.d_wdata = 32'h1234;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst d_gnt",   32'(bus.d_gnt),   0);
        chk("rst if_gnt",  32'(bus.if_gnt),  0);
        chk("rst mem_en",  32'(bus.mem_en),  0);
        chk("rst mem_we",  32'(bus.mem_we),  0);
        chk("rst stall_f", 32'(bus.stall_f), 0);
        chk("rst stall_m", 32'(bus.stall_m), 0);
        chk("rst rvalid",  32'({bus.if_rvalid, bus.d_rvalid}), 0);
        bus.if_req = 0; bus.d_req = 0; bus.d_we = 0;
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 22; i++) begin
            @(negedge clk);
            apply(tbl[i].ir, tbl[i].ia, tbl[i].fl, tbl[i].dr, tbl[i].dwe, tbl[i].da,
                  tbl[i].dwd, g_if, g_d, rv_if, rv_d, rd);
            chk("tbl if_gnt",    32'(g_if),  32'(tbl[i].e_ig));
            chk("tbl d_gnt",     32'(g_d),   32'(tbl[i].e_dg));
            chk("tbl if_rvalid", 32'(rv_if), 32'(tbl[i].e_irv));
            chk("tbl d_rvalid",  32'(rv_d),  32'(tbl[i].e_drv));
            if (tbl[i].chk_rd) chk("tbl d_rdata", rd, tbl[i].e_drd);
        end

        // reset while a load response is outstanding
        step(1, 32'h30, 0, 1, 0, 32'h118, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst-mid d_rvalid", 32'(bus.d_rvalid), 0);
        chk("rst-mid d_rdata",  bus.d_rdata,       0);
        chk("rst-mid d_gnt",    32'(bus.d_gnt),    0);
        chk("rst-mid mem_en",   32'(bus.mem_en),   0);
        chk("rst-mid stall_m",  32'(bus.stall_m),  0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        apply(1, 32'h30, 0, 1, 0, 32'h118, 0, g_if, g_d, rv_if, rv_d, rd);
        step(0, 0, 0, 0, 0, 0, 0);

        // random traffic over a small window so stores get read back
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 1)), 32'($urandom_range(0, 255)) << 2,
                 1'($urandom_range(0, 3) == 0),
                 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 2) == 0),
                 32'($urandom_range(0, 255)) << 2, 32'($urandom));
        end
        // long contention bursts to hammer the streak limit
        for (int i = 0; i < 40; i++) begin
            step(1, 32'h80, 0, 1, 1'($urandom_range(0, 1)),
                 32'($urandom_range(0, 255)) << 2, 32'($urandom));
        end
        step(0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one single-ported, synchronous unified memory between the fetch stage (instruction reads) and the memory stage (data loads and stores).
- Data requests have priority. A bounded-streak rule guarantees that fetch is not starved.
- Drives stall signals to the pipeline registers and returns read data with fixed one-cycle latency.
- Sits between the core (fetch and memory stages) and the memory macro, replacing the separate instruction and data memories.

Parameters:
- ADDR_W, 32, address width for both requesters and the memory.
- DATA_W, 32, data width.
- MAX_DATA_STREAK, 4, maximum consecutive data grants while fetch waits; must be ≥ 1.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- if_req  in  1  fetch read request.
- if_addr  in  ADDR_W  fetch address (pc).
- flush  in  1  branch/jump redirect; kills the outstanding fetch response.
- if_gnt  out  1  fetch granted this cycle.
- if_rvalid  out  1  fetch read data valid.
- if_rdata  out  DATA_W  fetch read data.
- stall_f  out  1  hold the fetch/pc registers (= if_req & ~if_gnt).
- d_req  in  1  data request.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  store data.
- d_gnt  out  1  data granted this cycle.
- d_rvalid  out  1  load data valid.
- d_rdata  out  DATA_W  load data.
- stall_m  out  1  hold the memory stage (= d_req & ~d_gnt).
- mem_en  out  1  memory access enable.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data; valid the cycle after a read with mem_en=1.

Behaviour:
- Grant (combinational, same cycle):
  - data_win = d_req & (~if_req | streak < MAX_DATA_STREAK).
  - d_gnt = data_win.
  - if_gnt = if_req & ~data_win.
  - At most one grant per cycle.
- Memory drive:
  - mem_en = d_gnt | if_gnt.
  - Address and write data come from the winner.
  - mem_we = d_gnt & d_we.
  - With no grant: mem_addr/mem_wdata = 0, mem_en = 0.
- Streak counter (registered, width clog2(MAX_DATA_STREAK+1)):
  - Increments on d_gnt while if_req = 1.
  - Clears to 0 on if_gnt or when if_req = 0.
  - Saturates at MAX_DATA_STREAK.
  - After MAX_DATA_STREAK consecutive data grants with fetch waiting, the next cycle goes to fetch even if d_req = 1.
- Response owner register resp_owner ∈ {OWN_NONE, OWN_FETCH, OWN_DATA}:
  - Set at a read grant: OWN_DATA for a load, OWN_FETCH for a fetch.
  - Set to OWN_NONE for a store or no grant.
  - One cycle later: if_rvalid = (resp_owner == OWN_FETCH) & ~kill; d_rvalid = (resp_owner == OWN_DATA).
  - Both rdata outputs carry mem_rdata when their rvalid is 1, else 0.
- Stores complete in the grant cycle. No rvalid is produced for a store.
- Flush:
  - flush at cycle N with a fetch grant at N → registered kill = 1, and if_rvalid at N+1 is suppressed.
  - flush at cycle N with a fetch response at N → if_rvalid forced 0 at N.
  - flush never affects data grants or responses.
- Simultaneous events:
  - d_req and if_req with streak < MAX → data wins; stall_f = 1.
  - Both requests with streak == MAX → fetch wins; stall_m = 1.
- Reset (asynchronous, rst = 0):
  - resp_owner = OWN_NONE, streak = 0, kill = 0.
  - All rvalid outputs 0, rdata 0, grants and stalls 0, mem_en/mem_we 0.
  - Reset during an outstanding read discards the response.
  - Grants resume on the first edge after rst rises.
- Latency: grant to rvalid is exactly 1 cycle. Throughput is one access per cycle.

Decomposition:
- Package mem_arb_pkg:
  - owner_t enum (OWN_NONE, OWN_FETCH, OWN_DATA).
  - Default ADDR_W/DATA_W constants.
- Sub-module arb_streak_ctr: saturating streak counter.
  - Inputs: clk, rst, inc, clr.
  - Output: at_max.
  - Parameter: MAX.
- All other logic lives in mem_arbiter.

Test Plan:
1. Fetch only: if_req = 1, if_addr = 0x0, 0x4, 0x8 on consecutive cycles → if_gnt = 1 each cycle; if_rvalid = 1 one cycle later with the memory words; stall_f = 0.
2. Contention: if_req = 1 and d_req = 1 (load 0x100) in the same cycle → d_gnt = 1, if_gnt = 0, stall_f = 1; next cycle d_rvalid = 1 with d_rdata = mem[0x100].
3. Starvation guard: if_req = 1 and d_req = 1 held for 6 cycles, MAX_DATA_STREAK = 4 → d_gnt in cycles 0–3, if_gnt in cycle 4, d_gnt in cycle 5.
4. Store: d_req = 1, d_we = 1, d_addr = 0x200, d_wdata = 0xDEADBEEF → mem_we = 1 in the same cycle; d_rvalid = 0 the next cycle; a later load of 0x200 returns 0xDEADBEEF.
5. Flush: fetch granted at cycle N with flush = 1 at N → if_rvalid = 0 at N+1. Separately, flush = 1 in a fetch response cycle → if_rvalid = 0 in that cycle.
6. Reset mid-read: load granted at N, rst = 0 at N+0.5 → d_rvalid = 0, streak = 0, all outputs 0; normal grants after rst deasserts.
